// File: rtl/dot_result_reader_if.sv
// dot_result_reader_if: bus bundle between the dot-product engine, the result
// reader and the downstream sorter.
//   done / M                   : engine completion pulse and modulation order
//   inReadAddr                 : reader -> engine read address
//   in{a,b,c,d}{Real,Imag}     : engine read data, valid one cycle after address
//   outReal/outImag/outIdx/outLast/outValid/outReady : serial sample stream
//   busy / overrun             : reader status
// Modports: master = reader side, slave = engine/sorter/testbench side.
interface dot_result_reader_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 7
);
    logic                  done;
    logic [1:0]            M;
    logic [ADDR_WIDTH-1:0] inReadAddr;
    logic [WIDTH-1:0]      inaReal;
    logic [WIDTH-1:0]      inaImag;
    logic [WIDTH-1:0]      inbReal;
    logic [WIDTH-1:0]      inbImag;
    logic [WIDTH-1:0]      incReal;
    logic [WIDTH-1:0]      incImag;
    logic [WIDTH-1:0]      indReal;
    logic [WIDTH-1:0]      indImag;
    logic [WIDTH-1:0]      outReal;
    logic [WIDTH-1:0]      outImag;
    logic                  outValid;
    logic                  outReady;
    logic [ADDR_WIDTH+1:0] outIdx;
    logic                  outLast;
    logic                  busy;
    logic                  overrun;

    modport master (
        input  done, M,
        input  inaReal, inaImag, inbReal, inbImag,
        input  incReal, incImag, indReal, indImag,
        input  outReady,
        output inReadAddr,
        output outReal, outImag, outValid, outIdx, outLast,
        output busy, overrun
    );

    modport slave (
        output done, M,
        output inaReal, inaImag, inbReal, inbImag,
        output incReal, incImag, indReal, indImag,
        output outReady,
        input  inReadAddr,
        input  outReal, outImag, outValid, outIdx, outLast,
        input  busy, overrun
    );
endinterface

// File: rtl/dot_result_reader.sv
// dot_result_reader: drains the dot-product engine result buffer after done,
// reading four complex lanes (a..d) per address and serialising them into a
// valid/ready sample stream. Frame length is 4*N beats, N set by M
// (QPSK 4, QAM16 16, QAM64 64, QAM256 128 words, clamped to 2^ADDR_WIDTH).
// Ports: clk, rst (synchronous, active-high), bus (dot_result_reader_if.master).
// Optional macro READER_PREFETCH_EN: prefetches the next word into a spare hold
// register during lane 2 so the stream sustains one beat per cycle.
module dot_result_reader #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                clk,
    input  logic                rst,
    dot_result_reader_if.master bus
);
    localparam int unsigned IDX_WIDTH = ADDR_WIDTH + 2;
    localparam int unsigned MAX_WORDS = 32'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, EMIT} state_t;
    typedef logic [3:0][WIDTH-1:0] lanes_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [1:0]            lane_q, lane_d;
    lanes_t                hold_re_q, hold_re_d;
    lanes_t                hold_im_q, hold_im_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      out_re_q, out_re_d;
    logic [WIDTH-1:0]      out_im_q, out_im_d;
    logic                  out_valid_q, out_valid_d;
    logic [IDX_WIDTH-1:0]  out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    lanes_t                in_re, in_im;
    logic                  xfer;
    logic [1:0]            lane_n;
    logic [ADDR_WIDTH-1:0] word_n;

`ifdef READER_PREFETCH_EN
    lanes_t                spare_re_q, spare_re_d;
    lanes_t                spare_im_q, spare_im_d;
    logic                  pf_req_q, pf_req_d;   // prefetch address visible this cycle
    logic                  pf_cap_q, pf_cap_d;   // prefetch data valid this cycle
    lanes_t                nxt_re, nxt_im;
`endif

    // Index of the final word for a modulation order, clamped to the buffer depth.
    function automatic logic [ADDR_WIDTH-1:0] last_word(input logic [1:0] m);
        int unsigned n;
        case (m)
            2'b00:   n = 4;
            2'b01:   n = 16;
            2'b10:   n = 64;
            default: n = 128;
        endcase
        if (n > MAX_WORDS) n = MAX_WORDS;
        return ADDR_WIDTH'(n - 1);
    endfunction

    // Lane 0 = a ... lane 3 = d.
    assign in_re  = {bus.indReal, bus.incReal, bus.inbReal, bus.inaReal};
    assign in_im  = {bus.indImag, bus.incImag, bus.inbImag, bus.inaImag};
    assign xfer   = out_valid_q & bus.outReady;
    assign lane_n = lane_q + 2'd1;
    assign word_n = word_q + ADDR_WIDTH'(1);

`ifdef READER_PREFETCH_EN
    // Next word comes straight off the engine bus if it lands this cycle.
    assign nxt_re = pf_cap_q ? in_re : spare_re_q;
    assign nxt_im = pf_cap_q ? in_im : spare_im_q;
`endif

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            last_q      <= '0;
            lane_q      <= '0;
            hold_re_q   <= '0;
            hold_im_q   <= '0;
            addr_q      <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef READER_PREFETCH_EN
            spare_re_q  <= '0;
            spare_im_q  <= '0;
            pf_req_q    <= 1'b0;
            pf_cap_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            last_q      <= last_d;
            lane_q      <= lane_d;
            hold_re_q   <= hold_re_d;
            hold_im_q   <= hold_im_d;
            addr_q      <= addr_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
`ifdef READER_PREFETCH_EN
            spare_re_q  <= spare_re_d;
            spare_im_q  <= spare_im_d;
            pf_req_q    <= pf_req_d;
            pf_cap_q    <= pf_cap_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        last_d      = last_q;
        lane_d      = lane_q;
        hold_re_d   = hold_re_q;
        hold_im_d   = hold_im_q;
        addr_d      = addr_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
`ifdef READER_PREFETCH_EN
        spare_re_d  = spare_re_q;
        spare_im_d  = spare_im_q;
        pf_req_d    = 1'b0;
        pf_cap_d    = pf_req_q;
        if (pf_cap_q) begin
            spare_re_d = in_re;
            spare_im_d = in_im;
        end
`endif

        // A done arriving while a frame is in flight (including its final
        // beat cycle) is dropped and flagged.
        if (bus.done && busy_q) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.done) begin
                    last_d  = last_word(bus.M);
                    word_d  = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                hold_re_d   = in_re;
                hold_im_d   = in_im;
                lane_d      = 2'd0;
                out_re_d    = in_re[0];
                out_im_d    = in_im[0];
                out_idx_d   = {word_q, 2'd0};
                out_last_d  = 1'b0;
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (xfer) begin
                    if (lane_q == 2'd3) begin
                        if (word_q == last_q) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            busy_d      = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            word_d = word_n;
`ifdef READER_PREFETCH_EN
                            hold_re_d  = nxt_re;
                            hold_im_d  = nxt_im;
                            lane_d     = 2'd0;
                            out_re_d   = nxt_re[0];
                            out_im_d   = nxt_im[0];
                            out_idx_d  = {word_n, 2'd0};
                            out_last_d = 1'b0;
`else
                            addr_d      = word_n;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            state_d     = FETCH;
`endif
                        end
                    end else begin
                        lane_d     = lane_n;
                        out_re_d   = hold_re_q[lane_n];
                        out_im_d   = hold_im_q[lane_n];
                        out_idx_d  = {word_q, lane_n};
                        out_last_d = (lane_n == 2'd3) && (word_q == last_q);
`ifdef READER_PREFETCH_EN
                        // Entering lane 2 with words left: issue the next address.
                        if ((lane_q == 2'd1) && (word_q != last_q)) begin
                            addr_d   = word_n;
                            pf_req_d = 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.inReadAddr = addr_q;
    assign bus.outReal    = out_re_q;
    assign bus.outImag    = out_im_q;
    assign bus.outValid   = out_valid_q;
    assign bus.outIdx     = out_idx_q;
    assign bus.outLast    = out_last_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_dot_result_reader.sv
// tb_dot_result_reader: directed bench for dot_result_reader with a registered
// engine model returning real = addr*4+lane+1, imag = lane+1.
module tb_dot_result_reader;
    localparam int unsigned WIDTH      = 16;
    localparam int unsigned ADDR_WIDTH = 7;
`ifdef READER_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dot_result_reader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    dot_result_reader #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: read data valid one cycle after the address.
    always_ff @(posedge clk) begin
        bus.inaReal <= 16'({bus.inReadAddr, 2'd0}) + 16'd1;
        bus.inbReal <= 16'({bus.inReadAddr, 2'd0}) + 16'd2;
        bus.incReal <= 16'({bus.inReadAddr, 2'd0}) + 16'd3;
        bus.indReal <= 16'({bus.inReadAddr, 2'd0}) + 16'd4;
        bus.inaImag <= 16'd1;
        bus.inbImag <= 16'd2;
        bus.incImag <= 16'd3;
        bus.indImag <= 16'd4;
    end

    // Captured frame.
    int   q_re[$];
    int   q_im[$];
    int   q_idx[$];
    bit   q_last[$];
    int   stall_err;
    int   last_k;
    bit   timed_out;
    bit   busy_first;
    int   first_bad;
    logic [(1<<ADDR_WIDTH)-1:0] addr_cov;

    function automatic int frame_cycles(input int nwords);
        return PREFETCH ? (4 * nwords + 2) : (6 * nwords);
    endfunction

    function automatic bit ready_of(input int pattern, input int k);
        if (pattern == 0) return 1'b1;
        return ((k % 4) == 0) || ((k % 4) == 3);
    endfunction

    // Number of captured beats that differ from the expected frame.
    function automatic int bad_beats(input int nbeats);
        int bad;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < q_re.size() && i < nbeats; i++) begin
            if (q_re[i] != i + 1 || q_im[i] != (i % 4) + 1 || q_idx[i] != i ||
                q_last[i] != (i == nbeats - 1)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return bad;
    endfunction

    // Pulse done, drive outReady pattern, record every transferred beat.
    task automatic collect_frame(input logic [1:0] m, input int pattern, input int done_idx,
                                 input int stop_idx, input int max_cycles);
        bit stalled;
        bit pulsed;
        logic [WIDTH-1:0] s_re, s_im;
        logic [ADDR_WIDTH+1:0] s_idx;
        logic s_last;
        q_re.delete(); q_im.delete(); q_idx.delete(); q_last.delete();
        stall_err = 0; last_k = -1; timed_out = 1'b1; busy_first = 1'b0;
        addr_cov = '0; stalled = 1'b0; pulsed = 1'b0;
        s_re = '0; s_im = '0; s_idx = '0; s_last = 1'b0;
        @(negedge clk);
        bus.M        = m;
        bus.done     = 1'b1;
        bus.outReady = ready_of(pattern, 0);
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            bus.done = 1'b0;
            addr_cov[bus.inReadAddr] = 1'b1;
            if (stalled && (bus.outValid !== 1'b1 || bus.outReal !== s_re || bus.outImag !== s_im ||
                            bus.outIdx !== s_idx || bus.outLast !== s_last))
                stall_err++;
            if (stop_idx >= 0 && bus.outValid === 1'b1 && int'(bus.outIdx) == stop_idx) begin
                timed_out = 1'b0;
                return;
            end
            bus.outReady = ready_of(pattern, k);
            stalled = (bus.outValid === 1'b1) && !bus.outReady;
            s_re = bus.outReal; s_im = bus.outImag; s_idx = bus.outIdx; s_last = bus.outLast;
            if (bus.outValid === 1'b1 && bus.outReady) begin
                if (done_idx >= 0 && !pulsed && int'(bus.outIdx) == done_idx) begin
                    bus.done = 1'b1;
                    pulsed   = 1'b1;
                end
                if (q_re.size() == 0) busy_first = bus.busy;
                q_re.push_back(int'(bus.outReal));
                q_im.push_back(int'(bus.outImag));
                q_idx.push_back(int'(bus.outIdx));
                q_last.push_back(bus.outLast);
                if (bus.outLast === 1'b1) begin
                    last_k = k;
                    timed_out = 1'b0;
                    @(negedge clk);
                    bus.done = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.done = 1'b0; bus.M = 2'b00; bus.outReady = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.outValid !== 1'b0) begin n_errors++; $display("FAIL reset_outValid got=%b exp=0", bus.outValid); end
        n_checks++; if (bus.outReal !== 16'd0) begin n_errors++; $display("FAIL reset_outReal got=%0h exp=0", bus.outReal); end
        n_checks++; if (bus.outImag !== 16'd0) begin n_errors++; $display("FAIL reset_outImag got=%0h exp=0", bus.outImag); end
        n_checks++; if (bus.outIdx !== 9'd0) begin n_errors++; $display("FAIL reset_outIdx got=%0h exp=0", bus.outIdx); end
        n_checks++; if (bus.outLast !== 1'b0) begin n_errors++; $display("FAIL reset_outLast got=%b exp=0", bus.outLast); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        n_checks++; if (bus.inReadAddr !== 7'd0) begin n_errors++; $display("FAIL reset_addr got=%0h exp=0", bus.inReadAddr); end
    endtask

    task automatic test_qpsk();
        int bad;
        collect_frame(2'b00, 0, -1, -1, 200);
        bad = bad_beats(16);
        n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL qpsk_timeout got=%b exp=0", timed_out); end
        n_checks++; if (q_re.size() !== 16) begin n_errors++; $display("FAIL qpsk_beats got=%0d exp=16", q_re.size()); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL qpsk_order bad=%0d first=%0d exp=0", bad, first_bad); end
        n_checks++; if (busy_first !== 1'b1) begin n_errors++; $display("FAIL qpsk_busy_mid got=%b exp=1", busy_first); end
        n_checks++; if (last_k !== frame_cycles(4)) begin n_errors++; $display("FAIL qpsk_latency got=%0d exp=%0d", last_k, frame_cycles(4)); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL qpsk_busy_end got=%b exp=0", bus.busy); end
        n_checks++; if (bus.outValid !== 1'b0) begin n_errors++; $display("FAIL qpsk_valid_end got=%b exp=0", bus.outValid); end
    endtask

    task automatic test_backpressure();
        int bad;
        collect_frame(2'b01, 1, -1, -1, 1000);
        bad = bad_beats(64);
        n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL bp_timeout got=%b exp=0", timed_out); end
        n_checks++; if (q_re.size() !== 64) begin n_errors++; $display("FAIL bp_beats got=%0d exp=64", q_re.size()); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL bp_order bad=%0d first=%0d exp=0", bad, first_bad); end
        n_checks++; if (stall_err !== 0) begin n_errors++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL bp_busy_end got=%b exp=0", bus.busy); end
    endtask

    task automatic test_qam256();
        int bad;
        int nlast;
        collect_frame(2'b11, 0, -1, -1, 2000);
        bad = bad_beats(512);
        nlast = 0;
        foreach (q_last[i]) if (q_last[i]) nlast++;
        n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL q256_timeout got=%b exp=0", timed_out); end
        n_checks++; if (q_re.size() !== 512) begin n_errors++; $display("FAIL q256_beats got=%0d exp=512", q_re.size()); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL q256_order bad=%0d first=%0d exp=0", bad, first_bad); end
        n_checks++; if (addr_cov !== {128{1'b1}}) begin n_errors++; $display("FAIL q256_addr_cov got=%h exp=all ones", addr_cov); end
        n_checks++; if (nlast !== 1) begin n_errors++; $display("FAIL q256_last_count got=%0d exp=1", nlast); end
        n_checks++; if (last_k !== frame_cycles(128)) begin n_errors++; $display("FAIL q256_latency got=%0d exp=%0d", last_k, frame_cycles(128)); end
    endtask

    task automatic test_overrun();
        int bad;
        int active;
        collect_frame(2'b01, 0, 20, -1, 1000);
        bad = bad_beats(64);
        n_checks++; if (q_re.size() !== 64) begin n_errors++; $display("FAIL ovr_beats got=%0d exp=64", q_re.size()); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL ovr_order bad=%0d first=%0d exp=0", bad, first_bad); end
        n_checks++; if (bus.overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
        active = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.outValid !== 1'b0 || bus.busy !== 1'b0) active++;
        end
        n_checks++; if (active !== 0) begin n_errors++; $display("FAIL ovr_no_restart got=%0d exp=0", active); end
        n_checks++; if (bus.overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
    endtask

    task automatic test_done_on_last();
        int bad;
        int active;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL dol_clear got=%b exp=0", bus.overrun); end
        collect_frame(2'b00, 0, 15, -1, 200);
        bad = bad_beats(16);
        n_checks++; if (q_re.size() !== 16) begin n_errors++; $display("FAIL dol_beats got=%0d exp=16", q_re.size()); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL dol_order bad=%0d first=%0d exp=0", bad, first_bad); end
        n_checks++; if (bus.overrun !== 1'b1) begin n_errors++; $display("FAIL dol_overrun got=%b exp=1", bus.overrun); end
        active = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.outValid !== 1'b0 || bus.busy !== 1'b0) active++;
        end
        n_checks++; if (active !== 0) begin n_errors++; $display("FAIL dol_no_new_frame got=%0d exp=0", active); end
    endtask

    task automatic test_reset_mid();
        int bad;
        int active;
        collect_frame(2'b01, 0, -1, 9, 500);
        n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL rmid_reach9 got=%b exp=0", timed_out); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.outValid !== 1'b0) begin n_errors++; $display("FAIL rmid_valid got=%b exp=0", bus.outValid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL rmid_overrun got=%b exp=0", bus.overrun); end
        rst = 1'b0;
        active = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.outValid !== 1'b0 || bus.busy !== 1'b0) active++;
        end
        n_checks++; if (active !== 0) begin n_errors++; $display("FAIL rmid_quiet got=%0d exp=0", active); end
        collect_frame(2'b01, 0, -1, -1, 500);
        bad = bad_beats(64);
        n_checks++; if (q_re.size() !== 64) begin n_errors++; $display("FAIL rmid_beats got=%0d exp=64", q_re.size()); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rmid_order bad=%0d first=%0d exp=0", bad, first_bad); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL rmid_overrun_after got=%b exp=0", bus.overrun); end
        n_checks++; if (last_k !== frame_cycles(16)) begin n_errors++; $display("FAIL rmid_latency got=%0d exp=%0d", last_k, frame_cycles(16)); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_qpsk();
        test_backpressure();
        test_qam256();
        test_overrun();
        test_done_on_last();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
